// File: rtl/masked_subbytes_seq_if.sv
// Byte-lane bus between the SubBytes sequencer and the two-lane masked GF(2^8) inverse unit.
interface masked_subbytes_seq_if;
  logic [7:0] inv_a_sh0;
  logic [7:0] inv_a_sh1;
  logic [7:0] inv_b_sh0;
  logic [7:0] inv_b_sh1;
  logic [7:0] inv_random;
  logic [7:0] inv_a_res_sh0;
  logic [7:0] inv_a_res_sh1;
  logic [7:0] inv_b_res_sh0;
  logic [7:0] inv_b_res_sh1;

  modport master (
    output inv_a_sh0, inv_a_sh1, inv_b_sh0, inv_b_sh1, inv_random,
    input  inv_a_res_sh0, inv_a_res_sh1, inv_b_res_sh0, inv_b_res_sh1
  );

  modport slave (
    input  inv_a_sh0, inv_a_sh1, inv_b_sh0, inv_b_sh1, inv_random,
    output inv_a_res_sh0, inv_a_res_sh1, inv_b_res_sh0, inv_b_res_sh1
  );
endinterface

// File: rtl/masked_subbytes_seq.sv
// Masked SubBytes / InvSubBytes sequencer: streams 16 state bytes, two per cycle,
// through an external masked inverse unit and reassembles the transformed shares.
module masked_subbytes_seq #(
  parameter int unsigned INV_LAT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         decrypt,
  input  logic [127:0]                 state_sh0,
  input  logic [127:0]                 state_sh1,
  input  logic [7:0]                   rnd_in,
  output logic                         rnd_req,
  masked_subbytes_seq_if.master        inv,
  output logic [127:0]                 out_sh0,
  output logic [127:0]                 out_sh1,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Inverse affine map (bit i <- b[i+2]^b[i+5]^b[i+7]) expressed as byte rotations.
  function automatic logic [7:0] inv_aff(input logic [7:0] b);
    return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]};
  endfunction

  function automatic logic [7:0] fwd_aff(input logic [7:0] x);
    return x ^ {x[3:0], x[7:4]} ^ {x[4:0], x[7:5]} ^ {x[5:0], x[7:6]} ^ {x[6:0], x[7]};
  endfunction

  state_e               state_q, state_d;
  logic [127:0]         sh0_q, sh0_d, sh1_q, sh1_d;
  logic                 dec_q, dec_d;
  logic [2:0]           iss_q, iss_d;
  logic                 iss_end_q, iss_end_d;
  logic [2:0]           rcv_q, rcv_d;
  logic [INV_LAT-1:0]   vld_q, vld_d;
  logic [127:0]         out_sh0_q, out_sh0_d, out_sh1_q, out_sh1_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 issue;
  logic                 tail;
  logic [6:0]           a_base, b_base, r_base;
  logic [7:0]           a0, a1, b0, b1;
  logic [7:0]           lane_a0, lane_a1, lane_b0, lane_b1;
  logic [7:0]           ra0, ra1, rb0, rb1;

  always_comb begin
    state_d   = state_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    dec_d     = dec_q;
    iss_d     = iss_q;
    iss_end_d = iss_end_q;
    rcv_d     = rcv_q;
    vld_d     = vld_q;
    out_sh0_d = out_sh0_q;
    out_sh1_d = out_sh1_q;

    issue  = (state_q == RUN) && !iss_end_q;
    tail   = vld_q[INV_LAT-1];
    a_base = {iss_q, 4'h0};
    b_base = {iss_q, 4'h8};
    r_base = {rcv_q, 4'h0};

    a0 = sh0_q[a_base +: 8];
    a1 = sh1_q[a_base +: 8];
    b0 = sh0_q[b_base +: 8];
    b1 = sh1_q[b_base +: 8];
    if (dec_q) begin
      a0 = inv_aff(a0) ^ 8'h05;
      a1 = inv_aff(a1);
      b0 = inv_aff(b0) ^ 8'h05;
      b1 = inv_aff(b1);
    end
    lane_a0 = issue ? a0 : '0;
    lane_a1 = issue ? a1 : '0;
    lane_b0 = issue ? b0 : '0;
    lane_b1 = issue ? b1 : '0;

    ra0 = inv.inv_a_res_sh0;
    ra1 = inv.inv_a_res_sh1;
    rb0 = inv.inv_b_res_sh0;
    rb1 = inv.inv_b_res_sh1;
    if (!dec_q) begin
      ra0 = fwd_aff(ra0) ^ 8'h63;
      ra1 = fwd_aff(ra1);
      rb0 = fwd_aff(rb0) ^ 8'h63;
      rb1 = fwd_aff(rb1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          sh0_d     = state_sh0;
          sh1_d     = state_sh1;
          dec_d     = decrypt;
          iss_d     = '0;
          iss_end_d = 1'b0;
          rcv_d     = '0;
          vld_d     = '0;
          out_sh0_d = '0;
          out_sh1_d = '0;
        end
      end
      RUN: begin
        if (issue) begin
          iss_d = iss_q + 3'd1;
          if (iss_q == 3'd7) iss_end_d = 1'b1;
        end
        vld_d = {vld_q[INV_LAT-2:0], issue};
        // Results are only trusted when the tail valid bit says they belong to an issue.
        if (tail) begin
          out_sh0_d[r_base +: 8]        = ra0;
          out_sh1_d[r_base +: 8]        = ra1;
          out_sh0_d[(r_base + 7'd8) +: 8] = rb0;
          out_sh1_d[(r_base + 7'd8) +: 8] = rb1;
          rcv_d = rcv_q + 3'd1;
          if (rcv_q == 3'd7) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh0_q     <= '0;
      sh1_q     <= '0;
      dec_q     <= 1'b0;
      iss_q     <= '0;
      iss_end_q <= 1'b0;
      rcv_q     <= '0;
      vld_q     <= '0;
      out_sh0_q <= '0;
      out_sh1_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      dec_q     <= dec_d;
      iss_q     <= iss_d;
      iss_end_q <= iss_end_d;
      rcv_q     <= rcv_d;
      vld_q     <= vld_d;
      out_sh0_q <= out_sh0_d;
      out_sh1_q <= out_sh1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign inv.inv_a_sh0  = lane_a0;
  assign inv.inv_a_sh1  = lane_a1;
  assign inv.inv_b_sh0  = lane_b0;
  assign inv.inv_b_sh1  = lane_b1;
  assign inv.inv_random = rnd_in;

  assign out_sh0 = out_sh0_q;
  assign out_sh1 = out_sh1_q;
  assign busy    = busy_q;
  assign rnd_req = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Bench for masked_subbytes_seq: behavioural masked inverse unit plus a result scoreboard
// checked against an S-box table built from GF(2^8) arithmetic.
module tb_masked_subbytes_seq;
  localparam int INV_LAT = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         decrypt;
  logic [127:0] state_sh0, state_sh1;
  logic [7:0]   rnd_in;
  logic         rnd_req;
  logic [127:0] out_sh0, out_sh1;
  logic         busy, done;

  masked_subbytes_seq_if inv_if ();

  masked_subbytes_seq #(.INV_LAT(INV_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .decrypt   (decrypt),
    .state_sh0 (state_sh0),
    .state_sh1 (state_sh1),
    .rnd_in    (rnd_in),
    .rnd_req   (rnd_req),
    .inv       (inv_if),
    .out_sh0   (out_sh0),
    .out_sh1   (out_sh1),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;
  int dn_cnt = 0;
  logic [127:0] exp_q[$];
  logic [7:0] ginv_t[256];
  logic [7:0] sbox_t[256];
  logic [7:0] isbox_t[256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Behavioural masked inverse unit: INV_LAT register stages, fresh output masks from inv_random.
  logic [7:0] pa0[INV_LAT], pa1[INV_LAT], pb0[INV_LAT], pb1[INV_LAT];
  always @(posedge clk) begin
    logic [7:0] ma, mb;
    ma = inv_if.inv_random;
    mb = {ma[3:0], ma[7:4]} ^ 8'h96;
    for (int i = INV_LAT - 1; i > 0; i--) begin
      pa0[i] <= pa0[i-1]; pa1[i] <= pa1[i-1];
      pb0[i] <= pb0[i-1]; pb1[i] <= pb1[i-1];
    end
    pa0[0] <= ginv_t[inv_if.inv_a_sh0 ^ inv_if.inv_a_sh1] ^ ma;
    pa1[0] <= ma;
    pb0[0] <= ginv_t[inv_if.inv_b_sh0 ^ inv_if.inv_b_sh1] ^ mb;
    pb1[0] <= mb;
  end
  assign inv_if.inv_a_res_sh0 = pa0[INV_LAT-1];
  assign inv_if.inv_a_res_sh1 = pa1[INV_LAT-1];
  assign inv_if.inv_b_res_sh0 = pb0[INV_LAT-1];
  assign inv_if.inv_b_res_sh1 = pb1[INV_LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rnd_in = 8'h00;
    forever begin
      @(negedge clk);
      rnd_in = 8'($urandom);
    end
  end

  // Scoreboard: every done pops one expected recombined state.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        dn_cnt++;
        if (exp_q.size() == 0) check("scoreboard_empty_at_done", {127'd0, done}, 128'd0);
        else check("result", out_sh0 ^ out_sh1, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] expect_of(input logic dec, input logic [127:0] s0,
                                             input logic [127:0] s1);
    logic [127:0] e;
    logic [7:0] x;
    for (int i = 0; i < 16; i++) begin
      x = s0[8*i +: 8] ^ s1[8*i +: 8];
      e[8*i +: 8] = dec ? isbox_t[x] : sbox_t[x];
    end
    return e;
  endfunction

  task automatic run_op(input logic dec, input logic [127:0] s0, input logic [127:0] s1);
    int n;
    exp_q.push_back(expect_of(dec, s0, s1));
    @(negedge clk);
    start = 1'b1; decrypt = dec; state_sh0 = s0; state_sh1 = s1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #2;
      n++;
      if (n == 1) begin
        check("busy_running", {127'd0, busy}, 128'd1);
        check("rnd_req_running", {127'd0, rnd_req}, 128'd1);
      end
      if (n == 10)
        check("lanes_idle_after_issue",
              {96'd0, inv_if.inv_a_sh0, inv_if.inv_a_sh1, inv_if.inv_b_sh0, inv_if.inv_b_sh1}, 128'd0);
      if (done) break;
    end
    check("done_latency", 128'(n), 128'd12);
    check("busy_at_done", {127'd0, busy}, 128'd0);
    @(posedge clk);
    #2 check("done_one_pulse", {127'd0, done}, 128'd0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] m, s0, r, e;
    int d0;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] p;
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gf_mul(p, 8'(a));
      ginv_t[a] = p;
    end
    for (int a = 0; a < 256; a++) begin
      logic [7:0] b;
      b = ginv_t[a];
      sbox_t[a] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      isbox_t[sbox_t[a]] = 8'(a);
    end

    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; state_sh0 = '0; state_sh1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_sh0", out_sh0, 128'd0);
    check("reset_out_sh1", out_sh1, 128'd0);
    check("reset_flags", {125'd0, busy, done, rnd_req}, 128'd0);
    check("reset_lanes",
          {96'd0, inv_if.inv_a_sh0, inv_if.inv_a_sh1, inv_if.inv_b_sh0, inv_if.inv_b_sh1}, 128'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(1'b0, '0, '0);

    run_op(1'b0, {16{8'hF6}}, {16{8'hA5}});
    check("sh0_not_plain", {127'd0, out_sh0 != {16{8'hED}}}, 128'd1);
    check("sh1_not_plain", {127'd0, out_sh1 != {16{8'hED}}}, 128'd1);

    run_op(1'b1, {16{8'hD1}}, {16{8'h3C}});
    m = rnd128();
    run_op(1'b1, {16{8'h63}} ^ m, m);

    m = rnd128();
    for (int i = 0; i < 16; i++) s0[8*i +: 8] = 8'(i) ^ m[8*i +: 8];
    run_op(1'b0, s0, m);
    r = out_sh0 ^ out_sh1;
    check("byte1", {120'd0, r[15:8]}, 128'h7C);
    check("byte15", {120'd0, r[127:120]}, 128'h76);

    for (int t = 0; t < 4; t++) begin
      m = rnd128();
      run_op(1'(t), rnd128(), m);
    end

    // start held for 20 cycles: one run, then a re-sampled start once back in IDLE
    m = rnd128(); s0 = rnd128();
    e = expect_of(1'b0, s0, m);
    exp_q.push_back(e);
    exp_q.push_back(e);
    d0 = dn_cnt;
    @(negedge clk);
    start = 1'b1; decrypt = 1'b0; state_sh0 = s0; state_sh1 = m;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1 start = 1'b0;
    #1 check("hold_single_done", 128'(dn_cnt - d0), 128'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (dn_cnt - d0 == 2) break;
    end
    check("hold_second_done", 128'(dn_cnt - d0), 128'd2);
    repeat (2) @(posedge clk);

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1; decrypt = 1'b0; state_sh0 = rnd128(); state_sh1 = rnd128();
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_out", out_sh0 | out_sh1, 128'd0);
    check("midreset_flags", {126'd0, busy, done}, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    d0 = dn_cnt;
    repeat (25) @(posedge clk);
    #2 check("no_spurious_done", 128'(dn_cnt - d0), 128'd0);
    m = rnd128();
    run_op(1'b1, rnd128(), m);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
